// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU responder: command encoding,
// controller states and the default operand width.
package alu_pkg;

    localparam int N_DEFAULT = 8;

    localparam logic [1:0] CMD_ADD = 2'b00;
    localparam logic [1:0] CMD_SUB = 2'b01;
    localparam logic [1:0] CMD_MUL = 2'b10;
    localparam logic [1:0] CMD_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_iter_step.sv
// One combinational iteration of shift-add multiply or restoring divide on
// the {acc, q} register pair; other commands pass the pair through untouched.
module alu_iter_step
    import alu_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [1:0]   cmd,
    input  logic [N-1:0] acc,
    input  logic [N-1:0] q,
    input  logic [N-1:0] operand,
    output logic [N-1:0] acc_next,
    output logic [N-1:0] q_next
);

    logic [N:0]   sum_s;
    logic [N:0]   partial_s;
    logic [N-1:0] diff_s;

    // Single multiply/divide step selected by the captured command
    always_comb begin
        sum_s     = {1'b0, acc} + {1'b0, operand};
        partial_s = {acc, q[N-1]};
        // partial < 2*divisor whenever it is restored, so N bits hold the difference
        diff_s    = partial_s[N-1:0] - operand;
        acc_next  = acc;
        q_next    = q;
        case (cmd)
            CMD_MUL: begin
                if (q[0]) begin
                    acc_next = sum_s[N:1];
                    q_next   = {sum_s[0], q[N-1:1]};
                end else begin
                    acc_next = {1'b0, acc[N-1:1]};
                    q_next   = {acc[0], q[N-1:1]};
                end
            end
            CMD_DIV: begin
                // A zero divisor always "fits": quotient saturates to ones, acc keeps the dividend
                if (partial_s >= {1'b0, operand}) begin
                    acc_next = diff_s;
                    q_next   = {q[N-2:0], 1'b1};
                end else begin
                    acc_next = partial_s[N-1:0];
                    q_next   = {q[N-2:0], 1'b0};
                end
            end
            default: begin
                acc_next = acc;
                q_next   = q;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_responder.sv
// Req/Ack responder: single-pass add/sub, N-iteration multiply/divide,
// 2N-bit registered result with a one-cycle Ack and back-to-back accept from DONE.
module alu_seq_responder
    import alu_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Req,
    input  logic [1:0]       Cmd,
    input  logic             cin,
    input  logic [N-1:0]     Op1,
    input  logic [N-1:0]     Op2,
    output logic [2*N-1:0]   Alu_Out,
    output logic             Ack,
    output logic             Busy
);

    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N);

    state_e           state_r;
    state_e           state_next_s;
    logic             accept_s;
    logic             finish_s;

    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       cmd_r;
    logic             cin_r;
    logic [N-1:0]     op1_r;
    logic [N-1:0]     op2_r;
    logic [N-1:0]     acc_r;
    logic [N-1:0]     q_r;

    logic [N-1:0]     step_operand_s;
    logic [N-1:0]     acc_next_s;
    logic [N-1:0]     q_next_s;
    logic [N:0]       add_s;
    logic [N:0]       sub_s;
    logic [2*N-1:0]   result_s;

    logic [2*N-1:0]   alu_out_r;
    logic             ack_r;
    logic             busy_r;

    assign Alu_Out = alu_out_r;
    assign Ack     = ack_r;
    assign Busy    = busy_r;

    // Controller state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and accept decode; Req is only looked at in IDLE and DONE
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (Req) begin
                    accept_s     = 1'b1;
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: begin
                if (cnt_r == CNT_ONE) begin
                    finish_s     = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = EXEC;
                end
            end
            DONE: begin
                if (Req) begin
                    accept_s     = 1'b1;
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Multiplicand for mul, divisor for div
    assign step_operand_s = (cmd_r == CMD_MUL) ? op1_r : op2_r;

    alu_iter_step #(
        .N (N)
    ) u_step (
        .cmd      (cmd_r),
        .acc      (acc_r),
        .q        (q_r),
        .operand  (step_operand_s),
        .acc_next (acc_next_s),
        .q_next   (q_next_s)
    );

    // Final result selection; mul/div take the last iteration's output directly
    always_comb begin
        add_s    = {1'b0, op1_r} + {1'b0, op2_r} + {{N{1'b0}}, cin_r};
        sub_s    = {1'b0, op1_r} - {1'b0, op2_r};
        result_s = {(2*N){1'b0}};
        case (cmd_r)
            CMD_ADD: result_s = {{(N-1){1'b0}}, add_s};
            CMD_SUB: result_s = {{(N-1){sub_s[N]}}, sub_s};
            CMD_MUL: result_s = {acc_next_s, q_next_s};
            CMD_DIV: result_s = {q_next_s, acc_next_s};
            default: result_s = {(2*N){1'b0}};
        endcase
    end

    // Operand capture, iteration registers and registered outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_r     <= {CNT_W{1'b0}};
            cmd_r     <= 2'b00;
            cin_r     <= 1'b0;
            op1_r     <= {N{1'b0}};
            op2_r     <= {N{1'b0}};
            acc_r     <= {N{1'b0}};
            q_r       <= {N{1'b0}};
            alu_out_r <= {(2*N){1'b0}};
            ack_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            ack_r  <= finish_s;
            busy_r <= (state_next_s != IDLE);
            if (accept_s) begin
                cmd_r <= Cmd;
                cin_r <= cin;
                op1_r <= Op1;
                op2_r <= Op2;
                acc_r <= {N{1'b0}};
                q_r   <= (Cmd == CMD_MUL) ? Op2 : Op1;
                cnt_r <= Cmd[1] ? CNT_FULL : CNT_ONE;
            end else if (state_r == EXEC) begin
                acc_r <= acc_next_s;
                q_r   <= q_next_s;
                cnt_r <= cnt_r - CNT_ONE;
            end
            if (finish_s) begin
                alu_out_r <= result_s;
            end
        end
    end

endmodule
